// File: rtl/cpu_control.sv
// cpu_common control enums and the cpu_control multi-cycle sequencer.
// cpu_control latches one opcode per handshake. It drives the ALU, the
// register-file write mux, the stack pointer, the fetch unit and the
// data-memory port. Memory-class opcodes wait in S_MEM for mem_ack, with an
// optional timeout abort.

package cpu_common;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
    ALU_XOR = 3'd4, ALU_MUL = 3'd5, ALU_SR  = 3'd6, ALU_SL = 3'd7
  } alu_operation_t;

  typedef enum logic {
    ALU_RX = 1'b0, ALU_IMMEDIATE = 1'b1
  } alu_operand_t;

  typedef enum logic [1:0] {
    RF_MUX_IMM = 2'd0, RF_MUX_R0 = 2'd1, RF_MUX_ALU = 2'd2, RF_MUX_MEM = 2'd3
  } rf_mux_src_t;

  typedef enum logic [1:0] {
    SP_NOP = 2'd0, SP_INC_2 = 2'd1, SP_DEC_2 = 2'd2
  } sp_operation_t;

  typedef enum logic [1:0] {
    FETCH_NOP = 2'd0, FETCH_INC_PC = 2'd1, FETCH_RET = 2'd2
  } fetch_operation_t;
endpackage

module cpu_control
  import cpu_common::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [4:0]       opcode,
  input  logic             mem_ack,
  output alu_operation_t   alu_op,
  output alu_operand_t     alu_operand,
  output rf_mux_src_t      rf_mux_src,
  output logic             rf_we,
  output sp_operation_t    sp_op,
  output fetch_operation_t fetch_op,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal,
  output logic             mem_error
);

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_HALT = 5'h01;
  localparam logic [4:0] OP_LDI  = 5'h12;
  localparam logic [4:0] OP_MOV  = 5'h13;
  localparam logic [4:0] OP_LD   = 5'h14;
  localparam logic [4:0] OP_ST   = 5'h15;
  localparam logic [4:0] OP_PUSH = 5'h16;
  localparam logic [4:0] OP_POP  = 5'h17;
  localparam logic [4:0] OP_RET  = 5'h18;

  // Counter is sized to hold MEM_TIMEOUT; with MEM_TIMEOUT = 0 it is a dummy bit.
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam bit TMO_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_HALT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [4:0]       op_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout_hit;

  assign timeout_hit = TMO_EN && (tmo_cnt == TMO_LIMIT);
  assign halted      = (state == S_HALT);

  // State register and opcode latch (opcode captured on the accept handshake).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= OP_NOP;
    end else begin
      state <= state_next;
      if (state == S_IDLE && instr_valid) begin
        op_q <= opcode;
      end
    end
  end

  // Memory wait counter: zero outside S_MEM, counts un-acked S_MEM cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= {CNT_W{1'b0}};
    end else if (state != S_MEM) begin
      tmo_cnt <= {CNT_W{1'b0}};
    end else if (TMO_EN && !mem_ack && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt <= tmo_cnt;
    end
  end

  // Next-state and per-cycle control outputs for the latched opcode.
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    alu_op      = ALU_ADD;
    alu_operand = ALU_RX;
    rf_mux_src  = RF_MUX_IMM;
    rf_we       = 1'b0;
    sp_op       = SP_NOP;
    fetch_op    = FETCH_NOP;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    illegal     = 1'b0;
    mem_error   = 1'b0;

    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_IDLE;
        end
      end

      S_EXEC: begin
        state_next = S_IDLE;
        case (op_q) inside
          OP_NOP: begin
            fetch_op = FETCH_INC_PC;
          end
          OP_HALT: begin
            state_next = S_HALT;
          end
          [5'h02:5'h09]: begin
            alu_op      = alu_operation_t'(3'(op_q - 5'h02));
            alu_operand = ALU_RX;
            rf_mux_src  = RF_MUX_ALU;
            rf_we       = 1'b1;
            fetch_op    = FETCH_INC_PC;
          end
          [5'h0A:5'h11]: begin
            alu_op      = alu_operation_t'(3'(op_q - 5'h0A));
            alu_operand = ALU_IMMEDIATE;
            rf_mux_src  = RF_MUX_ALU;
            rf_we       = 1'b1;
            fetch_op    = FETCH_INC_PC;
          end
          OP_LDI: begin
            rf_mux_src = RF_MUX_IMM;
            rf_we      = 1'b1;
            fetch_op   = FETCH_INC_PC;
          end
          OP_MOV: begin
            rf_mux_src = RF_MUX_R0;
            rf_we      = 1'b1;
            fetch_op   = FETCH_INC_PC;
          end
          OP_LD, OP_POP, OP_RET: begin
            mem_req    = 1'b1;
            mem_we     = 1'b0;
            state_next = S_MEM;
          end
          OP_ST: begin
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            state_next = S_MEM;
          end
          OP_PUSH: begin
            sp_op      = SP_DEC_2;
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            state_next = S_MEM;
          end
          default: begin
            // Undefined opcode retires as NOP with a one-cycle flag.
            fetch_op = FETCH_INC_PC;
            illegal  = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_ST) || (op_q == OP_PUSH);
        if (mem_ack) begin
          // An ack in the timeout cycle still completes normally.
          state_next = S_IDLE;
          case (op_q)
            OP_LD: begin
              rf_we      = 1'b1;
              rf_mux_src = RF_MUX_MEM;
              fetch_op   = FETCH_INC_PC;
            end
            OP_POP: begin
              rf_we      = 1'b1;
              rf_mux_src = RF_MUX_MEM;
              sp_op      = SP_INC_2;
              fetch_op   = FETCH_INC_PC;
            end
            OP_RET: begin
              sp_op    = SP_INC_2;
              fetch_op = FETCH_RET;
            end
            default: begin
              fetch_op = FETCH_INC_PC;
            end
          endcase
        end else if (timeout_hit) begin
          // Abort: drop the request, flag the error, retire nothing.
          mem_req    = 1'b0;
          mem_we     = 1'b0;
          mem_error  = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_MEM;
        end
      end

      S_HALT: begin
        state_next = S_HALT;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
